// File: rtl/ctrl_stream_router.sv
// Control-word router: distributes one input stream to N_CHS channel FIFOs
// with unicast, broadcast and masked multicast, per-channel flush and a sticky error.
module ctrl_stream_router #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned N_CHS      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned SEL_W     = (N_CHS > 1) ? $clog2(N_CHS) : 1,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [1:0]                  i_mode,
    input  logic [SEL_W-1:0]            i_dev_sel,
    input  logic [N_CHS-1:0]            i_ch_mask,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic [N_CHS-1:0]            o_valid,
    input  logic [N_CHS-1:0]            i_ready,
    output logic [DATA_WIDTH*N_CHS-1:0] o_data,
    input  logic [N_CHS-1:0]            i_flush,
    output logic [LVL_W*N_CHS-1:0]      o_level,
    output logic                        o_route_err,
    input  logic                        i_err_clr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [N_CHS-1:0] w_target;
    logic [N_CHS-1:0] w_full;
    logic [N_CHS-1:0] w_valid;
    logic             w_accept;
    logic             r_route_err;

    always_comb begin
        w_target = '0;
        case (i_mode)
            2'd1:    w_target = '1;
            2'd2:    w_target = i_ch_mask;
            default: begin
                for (int k = 0; k < N_CHS; k++) begin
                    w_target[k] = (32'(i_dev_sel) == 32'(k));
                end
            end
        endcase
    end

    // Full flags come from registered pointers only, so i_ready never reaches o_ready.
    assign o_ready  = ~i_reset & (&(~w_target | ~w_full));
    assign w_accept = i_valid & o_ready;
    assign o_valid  = w_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_route_err <= 1'b0;
        end else if (w_accept && (w_target == '0)) begin
            r_route_err <= 1'b1;
        end else if (i_err_clr) begin
            r_route_err <= 1'b0;
        end
    end

    assign o_route_err = r_route_err;

    for (genvar g = 0; g < N_CHS; g++) begin : g_ch
        logic [PTR_W:0]          r_wptr;
        logic [PTR_W:0]          r_rptr;
        logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
        logic [LVL_W-1:0]        w_level;
        logic                    w_push;
        logic                    w_pop;

        // Wrap bit makes the pointer difference the exact occupancy, 0..FIFO_DEPTH.
        assign w_level   = r_wptr - r_rptr;
        assign w_full[g] = (w_level == LVL_W'(FIFO_DEPTH));
        assign w_valid[g] = (w_level != '0);
        assign w_push    = w_accept & w_target[g] & ~i_flush[g];
        assign w_pop     = w_valid[g] & i_ready[g] & ~i_flush[g];

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else if (i_flush[g]) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
        end

        assign o_data[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH] = r_mem[r_rptr[PTR_W-1:0]];
        assign o_level[LVL_W*(g+1)-1 -: LVL_W]          = w_level;
    end

endmodule

// File: doc/ctrl_stream_router.md
# ctrl_stream_router

Parametrised successor to the single-cycle control-stream crossbar. It distributes a control word stream (LLR tables, sync patterns, coefficients) to up to 16 decoder channels. Each channel has its own FIFO with valid/ready backpressure. Besides unicast, it supports broadcast and masked multicast, plus per-channel flush and a sticky routing-error flag. It sits between the control-stream input and the per-channel `i_ctrl_*` ports of the decoder array, inside the control clock domain.

## Interface
- `DATA_WIDTH`, 24, control word width.
- `N_CHS`, 4, number of output channels; legal range 1..16.
- `FIFO_DEPTH`, 8, words per channel FIFO; power of two, at least 2.
- Derived, not overridable:
  - `SEL_W = max(1, log2(N_CHS))`.
  - `LVL_W = log2(FIFO_DEPTH) + 1`.
- `i_clk`, in, 1, control clock; the single clock of the block.
- `i_reset`, in, 1, asynchronous, active-high reset.
- `i_mode`, in, 2, routing mode, sampled with each word: 0 unicast, 1 broadcast, 2 masked multicast, 3 reserved (treated as unicast).
- `i_dev_sel`, in, SEL_W, unicast target channel.
- `i_ch_mask`, in, N_CHS, multicast target mask; bit k selects channel k.
- `i_valid`, in, 1, input word valid.
- `o_ready`, out, 1, input ready; combinational.
- `i_data`, in, DATA_WIDTH, input word.
- `o_valid`, out, N_CHS, per-channel output valid.
- `i_ready`, in, N_CHS, per-channel output ready.
- `o_data`, out, DATA_WIDTH*N_CHS, channel k on bits `[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]`.
- `i_flush`, in, N_CHS, per-channel synchronous flush.
- `o_level`, out, LVL_W*N_CHS, per-channel FIFO occupancy, range 0..FIFO_DEPTH.
- `o_route_err`, out, 1, sticky routing error.
- `i_err_clr`, in, 1, clears `o_route_err`.

## Operation
- **Target mask T.** Computed combinationally from `i_mode`, `i_dev_sel` and `i_ch_mask`:
  - Unicast: one-hot of `i_dev_sel`, or all zeros if `i_dev_sel >= N_CHS`.
  - Broadcast: all ones.
  - Masked multicast: `i_ch_mask`.
- **Input ready.** `o_ready = ~i_reset & AND over k of (~T[k] | ~full[k])`.
  - A full target stalls the whole word; no partial delivery.
  - A pop in the same cycle does not free a slot for a push in that cycle (no full-bypass).
- **Accept.** Occurs when `i_valid & o_ready`. The word is written to every FIFO k with T[k]=1.
- **Empty T on accept.** Covers an out-of-range `i_dev_sel` or a zero mask. `o_ready` is 1, the word is consumed and discarded, and `o_route_err` sets on the next edge.
- **Error flag.** `o_route_err` stays set until `i_err_clr`. If set and clear occur in the same cycle, set wins.
- **Channel FIFO.**
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH) plus a wrap bit; pointers wrap modulo FIFO_DEPTH.
  - Output is first-word-fall-through: `o_valid[k] = (level[k] != 0)`, and `o_data[k]` shows the head word.
  - Pop occurs when `o_valid[k] & i_ready[k]`.
  - `o_data[k]` while `o_valid[k]=0` is don't-care.
- **Level.** `level` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop (legal whenever not full).
- **Flush.** `i_flush[k]` clears pointers and level of FIFO k on the next edge.
  - A push to k in the same cycle is dropped for k only; other targets still receive the word.
  - A pop in the same cycle is void.
  - Flush has no effect on `o_ready` in that cycle.
- **Stability.** `i_mode`, `i_dev_sel`, `i_ch_mask` and `i_data` must be held stable while `i_valid=1` and `o_ready=0`.

## Timing
- **Reset.** On `i_reset` high, asynchronously:
  - all pointers and levels go to 0;
  - `o_valid` = 0, `o_level` = 0, `o_route_err` = 0;
  - FIFO storage is not reset;
  - `o_ready` = 0 while reset is high.
- **Mid-operation reset.** All queued words are lost; the first accepted word after deassertion is the first output.
- **Latency.** A word accepted on edge N is visible on `o_valid[k]`/`o_data[k]` after edge N, i.e. in cycle N+1. Only one register stage is allowed.
- **Throughput.** One word per cycle per channel when it is not stalled.
- **Full.** Level equal to FIFO_DEPTH deasserts `o_ready` in the same cycle for any word targeting that channel. `o_ready` returns one cycle after the pop edge.
- **Combinational paths.** `o_ready` depends combinationally on `i_mode`, `i_dev_sel`, `i_ch_mask` and the registered full flags only. There is no path from `i_ready` to `o_ready`.

## Test plan
- **Unicast.** `N_CHS=4`, `FIFO_DEPTH=8`; send 0x000001..0x000005 with `i_dev_sel=2` and `i_ready=4'hF` → only `o_valid[2]` pulses. Words arrive in order, each one cycle after accept. `o_level[2]` never exceeds 1.
- **Broadcast with backpressure.** `i_ready[1]=0`; send 10 broadcast words.
  - `o_ready` drops after the 8th accept.
  - `o_level[1]` = 8 and the other levels are 0.
  - Releasing `i_ready[1]` drains 0..7 and resumes acceptance one cycle after the first pop.
- **Masked multicast.** Mask 4'b1010 with word 0xABCDEF → channels 1 and 3 only.
  - Mask 0 → word consumed, `o_route_err`=1 on the next cycle, and it holds until `i_err_clr`.
  - `i_dev_sel=5` with `N_CHS=5` sets the error the same way.
- **Flush collision.** Fill channel 0 with 3 words, then assert `i_flush[0]` in the same cycle as a broadcast accept of 0x123456 → `o_level[0]`=0 next cycle, while channels 1..3 hold 0x123456.
- **Wrap-around.** Continuous push/pop of 100 incrementing words with `i_ready` toggling pseudo-randomly → output matches a reference queue. Level stays in 0..8, and pointers pass the wrap point 12 or more times.
- **Reset mid-stream.** Assert `i_reset` asynchronously with 5 words queued → `o_valid`, `o_level` and `o_route_err` go to 0 without a clock edge. The post-reset stream starts clean.
